fluxo_dados_param: RTL and testbench

FLUXO_DADOS_PARAM -- requirements
Module: fluxo_dados_param

---
 rtl/fluxo_dados_pkg.sv | 23 ++
 rtl/contador_mod.sv | 39 +++
 rtl/fluxo_dados_param.sv | 127 ++++++++++++
 tb/tb_fluxo_dados_param.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fluxo_dados_pkg.sv
// Shared constants and helpers for the Genius-style game datapath.
// Holds the default sizing of buttons, memory, rounds and inactivity timeout.
package fluxo_dados_pkg;

    localparam int NB_PADRAO        = 4;
    localparam int AW_PADRAO        = 4;
    localparam int N_RODADAS_PADRAO = 16;
    localparam int TIMEOUT_PADRAO   = 5000;

    // Bits needed to count 0..valor-1; valor is expected to be at least 2.
    function automatic int clog2(input int valor);
        int bits;
        int resto;
        bits  = 0;
        resto = valor - 1;
        while (resto > 0) begin
            bits  = bits + 1;
            resto = resto >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/contador_mod.sv
// Generic modulo counter with synchronous clear and enable.
// Wraps from MOD-1 to 0, or holds at MOD-1 when SATURA is set.
module contador_mod #(
    parameter int MOD    = 16,
    parameter int WIDTH  = 4,
    parameter bit SATURA = 1'b0
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_zera,
    input  logic             i_conta,
    output logic [WIDTH-1:0] o_valor,
    output logic             o_fim
);

    localparam logic [WIDTH-1:0] ULTIMO = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] r_valor;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_valor <= '0;
        end else if (i_zera) begin
            r_valor <= '0;
        end else if (i_conta) begin
            if (r_valor == ULTIMO) begin
                r_valor <= SATURA ? ULTIMO : '0;
            end else begin
                r_valor <= r_valor + 1'b1;
            end
        end
    end

    assign o_valor = r_valor;
    assign o_fim   = (r_valor == ULTIMO);

endmodule

// File: rtl/fluxo_dados_param.sv
// Datapath of the memory game: button edge detection, play register,
// sequence memory, play/round counters and inactivity timer.
module fluxo_dados_param
    import fluxo_dados_pkg::*;
#(
    parameter int NB        = NB_PADRAO,
    parameter int AW        = AW_PADRAO,
    parameter int N_RODADAS = N_RODADAS_PADRAO,
    parameter int TIMEOUT   = TIMEOUT_PADRAO
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        zera_jogada,
    input  logic                        conta_jogada,
    input  logic                        zera_rodada,
    input  logic                        conta_rodada,
    input  logic                        zera_reg,
    input  logic                        registra_reg,
    input  logic                        zera_inativo,
    input  logic                        conta_inativo,
    input  logic                        grava_mem,
    input  logic [NB-1:0]               botoes,
    output logic                        jogada_feita,
    output logic                        jogada_igual,
    output logic                        jogada_valida,
    output logic                        fim_jogada,
    output logic                        fim_rodada,
    output logic                        fim_jogo,
    output logic                        inativo,
    output logic                        db_tem_jogada,
    output logic [NB-1:0]               db_jogada,
    output logic [NB-1:0]               db_memoria,
    output logic [AW-1:0]               db_contagem,
    output logic [AW-1:0]               db_rodada,
    output logic [clog2(TIMEOUT)-1:0]   db_contagem_inativo
);

    localparam int CW    = clog2(TIMEOUT);
    localparam int DEPTH = 2 ** AW;

    logic          w_tem_jogada;
    logic          r_tem_prev;
    logic          r_jogada_feita;
    logic [NB-1:0] r_jogada;
    // NOTE: the memory has no reset; it starts at zero from its declaration
    // and keeps its contents across reset, so no reset branch is written.
    logic [NB-1:0] r_mem [DEPTH] = '{default: '0};

    assign w_tem_jogada = |botoes;

    // Previous level resets to 1 so a button held through reset release
    // is not mistaken for a new press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tem_prev     <= 1'b1;
            r_jogada_feita <= 1'b0;
        end else begin
            r_tem_prev     <= w_tem_jogada;
            r_jogada_feita <= w_tem_jogada & ~r_tem_prev;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_jogada <= '0;
        end else if (zera_reg) begin
            r_jogada <= '0;
        end else if (registra_reg) begin
            r_jogada <= botoes;
        end
    end

    // A write coinciding with reset is dropped so reset never alters memory.
    always_ff @(posedge clock) begin
        if (grava_mem && reset) begin
            r_mem[db_contagem] <= r_jogada;
        end
    end

    contador_mod #(
        .MOD    (N_RODADAS),
        .WIDTH  (AW),
        .SATURA (1'b0)
    ) u_cont_jogada (
        .i_clock (clock),
        .i_reset (reset),
        .i_zera  (zera_jogada),
        .i_conta (conta_jogada),
        .o_valor (db_contagem),
        .o_fim   (fim_jogada)
    );

    contador_mod #(
        .MOD    (N_RODADAS),
        .WIDTH  (AW),
        .SATURA (1'b0)
    ) u_cont_rodada (
        .i_clock (clock),
        .i_reset (reset),
        .i_zera  (zera_rodada),
        .i_conta (conta_rodada),
        .o_valor (db_rodada),
        .o_fim   (fim_jogo)
    );

    contador_mod #(
        .MOD    (TIMEOUT),
        .WIDTH  (CW),
        .SATURA (1'b1)
    ) u_cont_inativo (
        .i_clock (clock),
        .i_reset (reset),
        .i_zera  (zera_inativo),
        .i_conta (conta_inativo),
        .o_valor (db_contagem_inativo),
        .o_fim   (inativo)
    );

    assign db_tem_jogada = w_tem_jogada;
    assign jogada_feita  = r_jogada_feita;
    assign db_jogada     = r_jogada;
    assign db_memoria    = r_mem[db_contagem];
    assign jogada_igual  = (db_memoria == r_jogada);
    assign fim_rodada    = (db_contagem == db_rodada);
    assign jogada_valida = (r_jogada != '0) && ((r_jogada & (r_jogada - 1'b1)) == '0);

endmodule

// File: tb/tb_fluxo_dados_param.sv
// Self-checking bench for fluxo_dados_param: directed game scenarios,
// a vector table for the play register, and randomized traffic against a model.
module tb_fluxo_dados_param;

    localparam int NB = 4;
    localparam int AW = 4;
    localparam int NR = 16;
    localparam int TO = 8;
    localparam int CW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          zera_jogada, conta_jogada, zera_rodada, conta_rodada;
    logic          zera_reg, registra_reg, zera_inativo, conta_inativo, grava_mem;
    logic [NB-1:0] botoes;
    logic          jogada_feita, jogada_igual, jogada_valida, fim_jogada;
    logic          fim_rodada, fim_jogo, inativo, db_tem_jogada;
    logic [NB-1:0] db_jogada, db_memoria;
    logic [AW-1:0] db_contagem, db_rodada;
    logic [CW-1:0] db_contagem_inativo;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            m_cont, m_rod, m_inat;
    logic [NB-1:0] m_reg;
    logic [NB-1:0] m_mem [2**AW];
    bit            m_prev, m_feita;

    typedef struct {
        logic [NB-1:0] valor;
        logic          exp_valida;
    } vec_t;
    vec_t tab [8];

    fluxo_dados_param #(
        .NB        (NB),
        .AW        (AW),
        .N_RODADAS (NR),
        .TIMEOUT   (TO)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .zera_jogada         (zera_jogada),
        .conta_jogada        (conta_jogada),
        .zera_rodada         (zera_rodada),
        .conta_rodada        (conta_rodada),
        .zera_reg            (zera_reg),
        .registra_reg        (registra_reg),
        .zera_inativo        (zera_inativo),
        .conta_inativo       (conta_inativo),
        .grava_mem           (grava_mem),
        .botoes              (botoes),
        .jogada_feita        (jogada_feita),
        .jogada_igual        (jogada_igual),
        .jogada_valida       (jogada_valida),
        .fim_jogada          (fim_jogada),
        .fim_rodada          (fim_rodada),
        .fim_jogo            (fim_jogo),
        .inativo             (inativo),
        .db_tem_jogada       (db_tem_jogada),
        .db_jogada           (db_jogada),
        .db_memoria          (db_memoria),
        .db_contagem         (db_contagem),
        .db_rodada           (db_rodada),
        .db_contagem_inativo (db_contagem_inativo)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    task automatic clear_ctrl();
        zera_jogada   = 1'b0; conta_jogada  = 1'b0;
        zera_rodada   = 1'b0; conta_rodada  = 1'b0;
        zera_reg      = 1'b0; registra_reg  = 1'b0;
        zera_inativo  = 1'b0; conta_inativo = 1'b0;
        grava_mem     = 1'b0;
    endtask

    task automatic model_reset();
        m_cont = 0; m_rod = 0; m_inat = 0;
        m_reg  = '0;
        m_prev = 1'b1; m_feita = 1'b0;
    endtask

    // One rising edge of the game datapath, from the rules of each element.
    task automatic model_edge();
        if (grava_mem) m_mem[m_cont] = m_reg;
        m_feita = (botoes != 0) && !m_prev;
        m_prev  = (botoes != 0);
        if (zera_jogada)       m_cont = 0;
        else if (conta_jogada) m_cont = (m_cont + 1) % NR;
        if (zera_rodada)       m_rod = 0;
        else if (conta_rodada) m_rod = (m_rod + 1) % NR;
        if (zera_reg)          m_reg = '0;
        else if (registra_reg) m_reg = botoes;
        if (zera_inativo)       m_inat = 0;
        else if (conta_inativo) m_inat = (m_inat + 1 > TO - 1) ? TO - 1 : m_inat + 1;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string t);
        check({t, ".tem"},     db_tem_jogada,       botoes != 0);
        check({t, ".feita"},   jogada_feita,        m_feita);
        check({t, ".cont"},    db_contagem,         m_cont);
        check({t, ".rodada"},  db_rodada,           m_rod);
        check({t, ".jogada"},  db_jogada,           m_reg);
        check({t, ".mem"},     db_memoria,          m_mem[m_cont]);
        check({t, ".inat"},    db_contagem_inativo, m_inat);
        check({t, ".fimjog"},  fim_jogada,          m_cont == NR - 1);
        check({t, ".fimjogo"}, fim_jogo,            m_rod == NR - 1);
        check({t, ".fimrod"},  fim_rodada,          m_cont == m_rod);
        check({t, ".igual"},   jogada_igual,        m_mem[m_cont] == m_reg);
        check({t, ".valida"},  jogada_valida,       $countones(m_reg) == 1);
        check({t, ".inativo"}, inativo,             m_inat == TO - 1);
    endtask

    initial begin
        tab[0] = '{4'b0110, 1'b0};
        tab[1] = '{4'b0000, 1'b0};
        tab[2] = '{4'b0001, 1'b1};
        tab[3] = '{4'b1000, 1'b1};
        tab[4] = '{4'b1111, 1'b0};
        tab[5] = '{4'b0100, 1'b1};
        tab[6] = '{4'b0011, 1'b0};
        tab[7] = '{4'b0010, 1'b1};

        for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;

        // Reset with a button held through release
        reset  = 1'b0;
        botoes = 4'b0010;
        clear_ctrl();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        reset = 1'b1;
        tick();
        check("no_pulse_after_reset", jogada_feita, 1'b0);
        check_all("release");
        botoes = 4'b0000;
        tick();
        check_all("btn_release");
        botoes = 4'b0100;
        tick();
        check("pulse_after_press", jogada_feita, 1'b1);
        tick();
        check("pulse_single", jogada_feita, 1'b0);
        tick();
        check("hold_no_retrigger", jogada_feita, 1'b0);
        check_all("hold");

        // Play counter full lap and clear priority
        zera_jogada = 1'b1; tick(); zera_jogada = 1'b0;
        conta_jogada = 1'b1;
        for (int i = 1; i <= NR; i++) begin
            tick();
            check("cont_lap", db_contagem, i % NR);
            check("fim_jogada_lap", fim_jogada, (i % NR) == NR - 1);
        end
        tick();
        zera_jogada = 1'b1;
        tick();
        check("zera_over_conta", db_contagem, 0);
        clear_ctrl();
        check_all("cont");

        // Memory write at address 3 and compare
        conta_jogada = 1'b1;
        repeat (3) tick();
        conta_jogada = 1'b0;
        registra_reg = 1'b1; botoes = 4'b1000; tick();
        registra_reg = 1'b0; botoes = 4'b0000;
        grava_mem = 1'b1; tick(); grava_mem = 1'b0;
        check("mem_addr3", db_memoria, 4'b1000);
        registra_reg = 1'b1; botoes = 4'b1000; tick();
        registra_reg = 1'b0; botoes = 4'b0000;
        check("igual_addr3", jogada_igual, 1'b1);
        check_all("mem3");
        conta_jogada = 1'b1; tick(); conta_jogada = 1'b0;
        check("cont_addr4", db_contagem, 4);
        check("igual_addr4", jogada_igual, 1'b0);

        // Play register vector table
        for (int i = 0; i < 8; i++) begin
            registra_reg = 1'b1;
            botoes = tab[i].valor;
            tick();
            registra_reg = 1'b0;
            check("tab_jogada", db_jogada, tab[i].valor);
            check("tab_valida", jogada_valida, tab[i].exp_valida);
            check_all("tab");
        end
        botoes = 4'b0000;
        zera_reg = 1'b1; registra_reg = 1'b1; botoes = 4'b0101;
        tick();
        check("zera_reg_prio", db_jogada, 4'b0000);
        clear_ctrl(); botoes = 4'b0000;

        // Inactivity saturation
        zera_inativo = 1'b1; tick(); zera_inativo = 1'b0;
        conta_inativo = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("inat_cnt", db_contagem_inativo, (i > 7) ? 7 : i);
            check("inat_flag", inativo, i >= 7);
        end
        zera_inativo = 1'b1;
        tick();
        check("inat_clear_cnt", db_contagem_inativo, 0);
        check("inat_clear_flag", inativo, 1'b0);
        clear_ctrl();

        // Asynchronous reset mid-count; memory survives
        zera_rodada = 1'b1; zera_inativo = 1'b1; tick(); clear_ctrl();
        conta_rodada = 1'b1; repeat (5) tick(); conta_rodada = 1'b0;
        conta_inativo = 1'b1; repeat (3) tick(); conta_inativo = 1'b0;
        check("pre_rst_rodada", db_rodada, 5);
        check("pre_rst_inat", db_contagem_inativo, 3);
        reset = 1'b0;
        #1;
        model_reset();
        check("async_rodada", db_rodada, 0);
        check("async_inat", db_contagem_inativo, 0);
        check("async_cont", db_contagem, 0);
        check_all("async_rst");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        conta_jogada = 1'b1; repeat (3) tick(); conta_jogada = 1'b0;
        check("mem_preserved", db_memoria, 4'b1000);
        check_all("post_rst");

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            zera_jogada   = ($urandom_range(15) == 0);
            conta_jogada  = $urandom_range(1);
            zera_rodada   = ($urandom_range(15) == 0);
            conta_rodada  = ($urandom_range(3) == 0);
            zera_reg      = ($urandom_range(15) == 0);
            registra_reg  = ($urandom_range(2) == 0);
            zera_inativo  = ($urandom_range(11) == 0);
            conta_inativo = $urandom_range(1);
            grava_mem     = ($urandom_range(3) == 0);
            if ($urandom_range(2) == 0) botoes = NB'($urandom_range(15));
            check_all("rnd_pre");
            tick();
            check_all("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
